// File: rtl/ldlt_result_rx.sv
// Receiver for the LDLT factorization result stream: tags each word with (row, col),
// buffers it and re-emits it on valid/ready. Optional D-sign check: LDLT_RX_DIAG_CHECK_EN.
module ldlt_result_rx #(
    parameter int DATA_LEN   = 32,
    parameter int NODE_NUM   = 100,
    parameter int FRACTION   = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_valid,
    input  logic [DATA_LEN-1:0] i_data,
    output logic                o_valid,
    input  logic                o_ready,
    output logic [DATA_LEN-1:0] o_data,
    output logic [9:0]          o_row,
    output logic [9:0]          o_col,
    output logic                o_is_diag,
    output logic                o_last,
    output logic                o_done,
    output logic                o_overflow,
    output logic                o_err,
    output logic                o_diag_nonpos
);

    localparam int DIM = 6 * NODE_NUM;
    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int EW  = DATA_LEN + 22;
    localparam logic [9:0]  LAST_IDX = 10'(DIM - 1);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    // FRACTION only scales the data format; the sign check does not need it.
    if (DIM > 1023 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        FRACTION < 0 || FRACTION >= DATA_LEN) begin : g_param_check
        $error("ldlt_result_rx: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, RECV, DRAIN} state_t;

    state_t         state, state_nxt;
    logic [9:0]     row, col;
    logic           beat, drain_hit, done;
    logic           is_diag_idx, is_last_idx;
    logic           empty, full, push, pop;
    logic [EW-1:0]  mem [FIFO_DEPTH];
    logic [EW-1:0]  head;
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count;
    logic           overflow, err, diag_nonpos;

    assign is_diag_idx = (row == col);
    assign is_last_idx = (row == LAST_IDX) && (col == LAST_IDX);
    assign empty       = (count == '0);
    assign full        = (count == FULL_CNT);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, RECV: begin
                if (i_valid) state_nxt = is_last_idx ? DRAIN : RECV;
            end
            DRAIN: begin
                if (empty) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        beat      = i_valid && (state != DRAIN);
        drain_hit = i_valid && (state == DRAIN);
        done      = (state == DRAIN) && empty;
    end

    // Counters follow every beat, dropped or not, so later words keep their coordinates.
    always_ff @(posedge clk) begin
        if (rst || done) begin
            row <= '0;
            col <= '0;
        end else if (beat) begin
            if (is_last_idx) begin
                row <= '0;
                col <= '0;
            end else if (row == LAST_IDX) begin
                col <= col + 10'd1;
                row <= col + 10'd1;
            end else begin
                row <= row + 10'd1;
            end
        end
    end

    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign pop  = !empty && o_ready;
    assign push = beat && (!full || pop);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {i_data, row, col, is_diag_idx, is_last_idx};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (beat && full && !pop) overflow <= 1'b1;
            if (drain_hit)            err      <= 1'b1;
        end
    end

`ifdef LDLT_RX_DIAG_CHECK_EN
    function automatic logic is_nonpos(input logic signed [DATA_LEN-1:0] v);
        return v <= 0;
    endfunction

    always_ff @(posedge clk) begin
        if (rst)                                          diag_nonpos <= 1'b0;
        else if (push && is_diag_idx && is_nonpos(i_data)) diag_nonpos <= 1'b1;
    end
`else
    assign diag_nonpos = 1'b0;
`endif

    // Head fields read as zero while the buffer is empty, matching the reset view.
    assign head    = mem[rd_ptr];
    assign o_valid = !empty;
    assign {o_data, o_row, o_col, o_is_diag, o_last} = empty ? '0 : head;
    assign o_done        = done;
    assign o_overflow    = overflow;
    assign o_err         = err;
    assign o_diag_nonpos = diag_nonpos;

endmodule

// File: tb/tb_ldlt_result_rx.sv
// Self-checking bench for ldlt_result_rx (NODE_NUM=1, DIM=6, FIFO_DEPTH=16) against a queue model.
module tb_ldlt_result_rx;

    localparam int DATA_LEN = 32;
    localparam int DEPTH    = 16;
    localparam int DIM      = 6;
    localparam int N        = DIM * (DIM + 1) / 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                i_valid = 1'b0;
    logic [DATA_LEN-1:0] i_data = '0;
    logic                o_ready = 1'b0;
    logic                o_valid, o_is_diag, o_last, o_done, o_overflow, o_err, o_diag_nonpos;
    logic [DATA_LEN-1:0] o_data;
    logic [9:0]          o_row, o_col;

    ldlt_result_rx #(.DATA_LEN(DATA_LEN), .NODE_NUM(1), .FRACTION(16), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data),
        .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_row(o_row), .o_col(o_col),
        .o_is_diag(o_is_diag), .o_last(o_last), .o_done(o_done), .o_overflow(o_overflow),
        .o_err(o_err), .o_diag_nonpos(o_diag_nonpos)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_LEN-1:0] data;
        logic [9:0]          row;
        logic [9:0]          col;
        logic                d;
        logic                l;
    } ent_t;

    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 0;
    int   exp_row [N];
    int   exp_col [N];
    ent_t q [$];
    int   m_k;
    bit   m_drain, m_ovf, m_err, m_dnp;
    int   m_drops;
    int   dut_pops, done_cnt, first_row, first_col;

    // Reference model: one call per clock; inputs applied at negedge, model advanced at posedge.
    task automatic tick(input logic v, input logic [DATA_LEN-1:0] d, input logic r);
        ent_t e;
        bit   pop, drain_exit;
        i_valid = v;
        i_data  = d;
        o_ready = r;
        if (o_valid && r) begin
            if (dut_pops == 0) begin
                first_row = int'(o_row);
                first_col = int'(o_col);
            end
            dut_pops++;
        end
        @(posedge clk);
        pop        = (q.size() != 0) && r;
        drain_exit = m_drain && (q.size() == 0);
        if (pop) void'(q.pop_front());
        if (v) begin
            if (m_drain) m_err = 1;
            else begin
                e.data = d;
                e.row  = 10'(exp_row[m_k]);
                e.col  = 10'(exp_col[m_k]);
                e.d    = (exp_row[m_k] == exp_col[m_k]);
                e.l    = (m_k == N - 1);
                if (q.size() < DEPTH) begin
                    q.push_back(e);
                    if (e.d && $signed(d) <= 0) m_dnp = 1;
                end else begin
                    m_ovf = 1;
                    m_drops++;
                end
                if (e.l) begin
                    m_drain = 1;
                    m_k = 0;
                end else m_k++;
            end
        end
        if (drain_exit) m_drain = 0;
        @(negedge clk);
        if (o_done === 1'b1) done_cnt++;
    endtask

    task automatic do_reset();
        rst = 1; i_valid = 0; o_ready = 0;
        @(posedge clk);
        q.delete();
        m_k = 0; m_drain = 0; m_ovf = 0; m_err = 0; m_dnp = 0; m_drops = 0;
        dut_pops = 0; done_cnt = 0; first_row = -1; first_col = -1;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic drain(input bit rnd, output bit seen);
        int start = done_cnt;
        for (int n = 0; n < 600 && done_cnt == start; n++)
            tick(0, '0, rnd ? 1'($urandom_range(0, 1)) : 1'b1);
        seen = (done_cnt != start);
        tick(0, '0, 1);
        tick(0, '0, 1);
    endtask

    // Stream scoreboard: o_valid, head fields, o_done and sticky flags every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            logic exp_dnp;
`ifdef LDLT_RX_DIAG_CHECK_EN
            exp_dnp = m_dnp;
`else
            exp_dnp = 1'b0;
`endif
            checks++;
            if (o_valid !== (q.size() != 0)) begin
                failures++;
                $display("FAIL o_valid at %0t: got %b want %b", $time, o_valid, q.size() != 0);
            end
            if (q.size() != 0) begin
                checks++;
                if ({o_data, o_row, o_col, o_is_diag, o_last} !== q[0]) begin
                    failures++;
                    $display("FAIL head at %0t: got d=%h r=%0d c=%0d dg=%b l=%b want d=%h r=%0d c=%0d dg=%b l=%b",
                             $time, o_data, o_row, o_col, o_is_diag, o_last,
                             q[0].data, q[0].row, q[0].col, q[0].d, q[0].l);
                end
            end
            checks++;
            if (o_done !== (m_drain && q.size() == 0)) begin
                failures++;
                $display("FAIL o_done at %0t: got %b want %b", $time, o_done, m_drain && q.size() == 0);
            end
            checks++;
            if ({o_overflow, o_err, o_diag_nonpos} !== {m_ovf, m_err, exp_dnp}) begin
                failures++;
                $display("FAIL flags at %0t: got ovf/err/dnp=%b%b%b want %b%b%b", $time,
                         o_overflow, o_err, o_diag_nonpos, m_ovf, m_err, exp_dnp);
            end
        end
    end

    task automatic test_reset();
        for (int k = 0; k < 3; k++) tick(1, 32'(k + 1), 0);
        do_reset();
        checks++;
        if ({o_valid, o_data, o_row, o_col, o_is_diag, o_last} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got v=%b d=%h r=%0d c=%0d dg=%b l=%b want all 0",
                     o_valid, o_data, o_row, o_col, o_is_diag, o_last);
        end
        checks++;
        if ({o_done, o_overflow, o_err, o_diag_nonpos} !== 4'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b want 0000", {o_done, o_overflow, o_err, o_diag_nonpos});
        end
    endtask

    task automatic test_basic();
        bit seen;
        do_reset();
        for (int k = 0; k < N; k++) tick(1, 32'(k + 1), 1);
        drain(0, seen);
        checks++;
        if (!seen || done_cnt != 1) begin
            failures++;
            $display("FAIL basic_done: got %0d pulses want 1", done_cnt);
        end
        checks++;
        if (dut_pops != N) begin
            failures++;
            $display("FAIL basic_pops: got %0d want %0d", dut_pops, N);
        end
        checks++;
        if ({o_overflow, o_err} !== 2'b00) begin
            failures++;
            $display("FAIL basic_flags: got %b want 00", {o_overflow, o_err});
        end
    endtask

    task automatic test_gaps();
        bit seen;
        int sent = 0;
        do_reset();
        for (int c = 0; c < 400 && sent < N; c++) begin
            if (c % 2 == 1) begin
                tick(1, $urandom, 1'($urandom_range(0, 1)));
                sent++;
            end else tick(0, $urandom, 1'($urandom_range(0, 1)));
        end
        drain(1, seen);
        checks++;
        if (!seen || done_cnt != 1) begin
            failures++;
            $display("FAIL gaps_done: got %0d pulses want 1", done_cnt);
        end
        checks++;
        if (dut_pops + m_drops != N) begin
            failures++;
            $display("FAIL gaps_pops: got %0d want %0d", dut_pops, N - m_drops);
        end
    endtask

    task automatic test_overflow();
        bit seen;
        do_reset();
        for (int k = 0; k < N; k++) tick(1, 32'(k + 1), 0);
        checks++;
        if (o_overflow !== 1'b1 || o_valid !== 1'b1) begin
            failures++;
            $display("FAIL ovf_flag: got ovf=%b v=%b want 1 1", o_overflow, o_valid);
        end
        drain(0, seen);
        checks++;
        if (!seen || done_cnt != 1 || dut_pops != DEPTH) begin
            failures++;
            $display("FAIL ovf_drain: got pops=%0d done=%0d want %0d 1", dut_pops, done_cnt, DEPTH);
        end
    endtask

    task automatic test_back_to_back();
        bit seen;
        int p0;
        do_reset();
        for (int k = 0; k < DEPTH; k++) tick(1, $urandom, 0);
        p0 = dut_pops;
        for (int k = DEPTH; k < N; k++) tick(1, $urandom, 1);
        tick(0, '0, 1);
        checks++;
        if (dut_pops - p0 != N - DEPTH + 1 || o_overflow !== 1'b0) begin
            failures++;
            $display("FAIL b2b_throughput: got pops=%0d ovf=%b want %0d 0",
                     dut_pops - p0, o_overflow, N - DEPTH + 1);
        end
        drain(0, seen);
        checks++;
        if (!seen || dut_pops != N) begin
            failures++;
            $display("FAIL b2b_drain: got pops=%0d want %0d", dut_pops, N);
        end
    endtask

    task automatic test_drain_err();
        bit seen;
        do_reset();
        for (int k = 0; k < N; k++) tick(1, 32'(k + 100), (k < N - 3) ? 1'b1 : 1'b0);
        for (int k = 0; k < 3; k++) tick(1, 32'hDEAD0000 + 32'(k), 0);
        checks++;
        if (o_err !== 1'b1) begin
            failures++;
            $display("FAIL drain_err: got %b want 1", o_err);
        end
        drain(0, seen);
        checks++;
        if (!seen || dut_pops != N || done_cnt != 1) begin
            failures++;
            $display("FAIL drain_err_seq: got pops=%0d done=%0d want %0d 1", dut_pops, done_cnt, N);
        end
    endtask

    task automatic test_diag();
        bit   seen;
        logic want;
`ifdef LDLT_RX_DIAG_CHECK_EN
        want = 1'b1;
`else
        want = 1'b0;
`endif
        do_reset();
        for (int k = 0; k < N; k++) begin
            tick(1, (k == 11) ? 32'hFFFF0000 : 32'($urandom_range(1, 100000)), 1);
            if (k == 10 || k == 11) begin
                checks++;
                if (o_diag_nonpos !== ((k == 11) ? want : 1'b0)) begin
                    failures++;
                    $display("FAIL diag_nonpos beat %0d: got %b want %b", k, o_diag_nonpos,
                             (k == 11) ? want : 1'b0);
                end
            end
        end
        drain(0, seen);
    endtask

    task automatic test_reset_mid();
        bit seen;
        do_reset();
        for (int k = 0; k < 10; k++) tick(1, 32'hBAD00000 + 32'(k), 0);
        do_reset();
        checks++;
        if (o_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrst_empty: got %b want 0", o_valid);
        end
        for (int k = 0; k < N; k++) tick(1, 32'(k + 1), 1);
        drain(0, seen);
        checks++;
        if (!seen || dut_pops != N || first_row != 0 || first_col != 0) begin
            failures++;
            $display("FAIL midrst_restart: got pops=%0d first=(%0d,%0d) want %0d (0,0)",
                     dut_pops, first_row, first_col, N);
        end
    endtask

    initial begin
        int k = 0;
        for (int j = 0; j < DIM; j++)
            for (int i = j; i < DIM; i++) begin
                exp_row[k] = i;
                exp_col[k] = j;
                k++;
            end
        @(negedge clk);
        do_reset();
        mon_en = 1;
        test_reset();
        test_basic();
        test_gaps();
        test_overflow();
        test_back_to_back();
        test_drain_err();
        test_diag();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
